// File: rtl/cordic_vectoring.sv
// cordic_vectoring
//   Iterative CORDIC in vectoring mode. Rotates the input vector (x,y) onto the
//   positive x axis and reports the accumulated rotation angle plus the final x
//   (magnitude scaled by the uncompensated CORDIC gain K_N).
//
//   State | meaning
//   IDLE  | waiting for start_i; operands latched on the accepting edge
//   LOAD  | detect the all-zero vector
//   PRE   | quadrant pre-rotation into the right half plane (+-90 deg)
//   ITER  | N micro-rotations, one per cycle
//   DONE  | results on mag_o/deg_o, valid_o pulses for this one cycle
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous reset, active high, overrides everything
//   start_i  in   job request, only honoured in IDLE
//   x_i/y_i  in   signed IN_W operands, captured with start_i
//   nIt_i    in   iteration count minus one (N = nIt_i+1), captured with start_i
//   bussy_o  out  high in every state except IDLE
//   valid_o  out  one-cycle result strobe
//   mag_o    out  unsigned magnitude ~ K_N*|v|, holds until next result/reset
//   deg_o    out  signed angle in degrees, Q9.7, holds until next result/reset
module cordic_vectoring #(
  parameter int IN_W     = 16,
  parameter int INT_W    = 18,
  parameter int ANG_FRAC = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [IN_W-1:0]  x_i,
  input  logic [IN_W-1:0]  y_i,
  input  logic [2:0]       nIt_i,
  output logic             bussy_o,
  output logic             valid_o,
  output logic [INT_W-1:0] mag_o,
  output logic [15:0]      deg_o
);

  localparam logic signed [15:0] DEG90 = 16'(90 << ANG_FRAC);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PRE, S_ITER, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [INT_W-1:0] r_x;
  logic signed [INT_W-1:0] r_y;
  logic signed [15:0]      r_z;
  logic [2:0]              r_n;
  logic [2:0]              r_nlast;
  logic                    r_zero;
  logic [INT_W-1:0]        r_mag;
  logic [15:0]             r_deg;

  logic                    w_d_pos;
  logic signed [INT_W-1:0] w_xs;
  logic signed [INT_W-1:0] w_ys;
  logic signed [15:0]      w_atan;
  logic signed [INT_W-1:0] w_x_it;
  logic signed [INT_W-1:0] w_y_it;
  logic signed [15:0]      w_z_it;
  logic                    w_last;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start_i) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = S_PRE;
      S_PRE:  w_state_nxt = S_ITER;
      S_ITER: if (w_last) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    bussy_o = (r_state != S_IDLE);
    valid_o = (r_state == S_DONE);
  end

  assign mag_o = r_mag;
  assign deg_o = r_deg;

  // ---------------- micro-rotation ----------------
  always_comb begin
    w_atan = 16'sd0;
    case (r_n)
      3'd0: w_atan = 16'sd5760;
      3'd1: w_atan = 16'sd3400;
      3'd2: w_atan = 16'sd1797;
      3'd3: w_atan = 16'sd912;
      3'd4: w_atan = 16'sd458;
      3'd5: w_atan = 16'sd229;
      3'd6: w_atan = 16'sd115;
      3'd7: w_atan = 16'sd57;
      default: w_atan = 16'sd0;
    endcase
  end

  assign w_d_pos = ~r_y[INT_W-1];
  assign w_xs    = r_x >>> r_n;
  assign w_ys    = r_y >>> r_n;
  assign w_x_it  = w_d_pos ? (r_x + w_ys)    : (r_x - w_ys);
  assign w_y_it  = w_d_pos ? (r_y - w_xs)    : (r_y + w_xs);
  assign w_z_it  = w_d_pos ? (r_z + w_atan)  : (r_z - w_atan);
  assign w_last  = (r_n == r_nlast);

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_n     <= '0;
      r_nlast <= '0;
      r_zero  <= 1'b0;
      r_mag   <= '0;
      r_deg   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_x     <= {{(INT_W-IN_W){x_i[IN_W-1]}}, x_i};
            r_y     <= {{(INT_W-IN_W){y_i[IN_W-1]}}, y_i};
            r_nlast <= nIt_i;
          end
        end
        S_LOAD: r_zero <= (r_x == '0) && (r_y == '0);
        S_PRE: begin
          r_n <= '0;
          // Left half plane is rotated by +-90 deg so iterations always
          // start with x >= 0; the two extra bits cover negating -2^(IN_W-1).
          if (r_x[INT_W-1] && !r_y[INT_W-1]) begin
            r_x <= r_y;
            r_y <= -r_x;
            r_z <= DEG90;
          end else if (r_x[INT_W-1] && r_y[INT_W-1]) begin
            r_x <= -r_y;
            r_y <= r_x;
            r_z <= -DEG90;
          end else begin
            r_z <= '0;
          end
        end
        S_ITER: begin
          r_x <= w_x_it;
          r_y <= w_y_it;
          r_z <= w_z_it;
          r_n <= r_n + 3'd1;
          // Results are captured on the edge that enters DONE so they are
          // already stable while valid_o is high.
          if (w_last) begin
            r_mag <= r_zero ? '0 : w_x_it;
            r_deg <= r_zero ? '0 : w_z_it;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
